move_engine: RTL and testbench

//  Executes one player move of the 24 game: takes operand slots and an operator from the keypad FSM, computes the result, and compacts the live number list.

---
 rtl/move_engine_pkg.sv | 30 +++
 rtl/move_engine_if.sv | 24 ++
 rtl/move_engine_seq_divider.sv | 71 +++++++
 rtl/move_engine.sv | 193 +++++++++++++++++++
 tb/tb_move_engine.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/move_engine_pkg.sv
// Shared types and constants for the 24-game move engine: operator and error
// codes, FSM state encodings, default width and winning target.
package move_engine_pkg;

   localparam int W_DEF      = 10;
   localparam int TARGET_DEF = 24;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_SEL     = 2'd1,
      ERR_ARITH   = 2'd2,
      ERR_INEXACT = 2'd3
   } err_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READY  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_DIV    = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

endpackage

// File: rtl/move_engine_if.sv
// Move request/response channel between the keypad FSM (master) and the
// move engine (slave).
interface move_engine_if;
   import move_engine_pkg::*;

   logic       req_valid;
   logic       req_ready;
   logic [1:0] sel_a;
   logic [1:0] sel_b;
   op_t        op;
   logic       resp_valid;
   err_t       resp_err;

   modport master (
      output req_valid, sel_a, sel_b, op,
      input  req_ready, resp_valid, resp_err
   );

   modport slave (
      input  req_valid, sel_a, sel_b, op,
      output req_ready, resp_valid, resp_err
   );

endinterface

// File: rtl/move_engine_seq_divider.sv
// W-bit restoring divider. The start edge performs the first iteration, so
// done is sampled high exactly W edges after start; abort cancels at once.
module seq_divider #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem_reg, quo_reg, dvs_reg;
   logic [CW-1:0] cnt_reg;
   logic          run_reg, done_reg;

   logic [W-1:0]  s_rem, s_quo, s_dvs;
   logic [W:0]    trial;
   logic          ge;
   logic [W-1:0]  rem_next, quo_next;

   // One restoring step; on start it works straight from the input operands.
   always_comb begin
      s_rem    = start ? '0 : rem_reg;
      s_quo    = start ? dividend : quo_reg;
      s_dvs    = start ? divisor : dvs_reg;
      trial    = {s_rem, s_quo[W-1]};
      ge       = (trial >= {1'b0, s_dvs});
      rem_next = ge ? W'(trial - {1'b0, s_dvs}) : trial[W-1:0];
      quo_next = {s_quo[W-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         run_reg  <= 1'b0;
         done_reg <= 1'b0;
         cnt_reg  <= '0;
         rem_reg  <= '0;
         quo_reg  <= '0;
         dvs_reg  <= '0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            dvs_reg <= s_dvs;
            cnt_reg <= CW'(W - 1);
            run_reg <= 1'b1;
         end else if (run_reg) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
               run_reg  <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign done      = done_reg;
   assign quotient  = quo_reg;
   assign remainder = rem_reg;

endmodule

// File: rtl/move_engine.sv
// Executes one 24-game move: owns the four number slots, live count and restart
// snapshot, computes a op b and compacts the live list on success.
module move_engine
   import move_engine_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int TARGET = TARGET_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [W-1:0]  init_num0,
   input  logic [W-1:0]  init_num1,
   input  logic [W-1:0]  init_num2,
   input  logic [W-1:0]  init_num3,
   input  logic          restart,
   move_engine_if.slave  bus,
   output logic [W-1:0]  num0,
   output logic [W-1:0]  num1,
   output logic [W-1:0]  num2,
   output logic [W-1:0]  num3,
   output logic [2:0]    count,
   output logic          busy,
   output logic          win
);

   state_t              state_reg;
   logic [3:0][W-1:0]   slot_reg, snap_reg, compact_next, init_vec;
   logic [2:0]          count_reg;
   logic [1:0]          sel_a_reg, sel_b_reg;
   op_t                 op_reg;
   logic [W-1:0]        a_reg, b_reg, result_reg;
   err_t                err_reg;
   logic                resp_valid_reg;
   err_t                resp_err_reg;

   logic                req_ready, abort, sel_bad, div_start;
   logic [W:0]          sum;
   logic [2*W-1:0]      prod;
   logic [W-1:0]        exec_res;
   err_t                exec_err;
   logic [1:0]          lo_sel, hi_sel;
   logic                div_done;
   logic [W-1:0]        div_quo, div_rem;

   assign init_vec  = {init_num3, init_num2, init_num1, init_num0};
   assign req_ready = (state_reg == ST_READY) && (count_reg >= 3'd2) && !load && !restart;
   assign abort     = load || (restart && state_reg != ST_IDLE);

   assign sel_bad = (sel_a_reg == sel_b_reg) || ({1'b0, sel_a_reg} >= count_reg)
                    || ({1'b0, sel_b_reg} >= count_reg);
   assign sum     = {1'b0, a_reg} + {1'b0, b_reg};
   assign prod    = {{W{1'b0}}, a_reg} * {{W{1'b0}}, b_reg};

   // A bad select outranks any arithmetic fault of the same move.
   always_comb begin
      exec_res = '0;
      exec_err = ERR_OK;
      case (op_reg)
         OP_ADD: begin
            exec_res = sum[W-1:0];
            if (sum[W]) exec_err = ERR_ARITH;
         end
         OP_SUB: begin
            exec_res = a_reg - b_reg;
            if (a_reg < b_reg) exec_err = ERR_ARITH;
         end
         OP_MUL: begin
            exec_res = prod[W-1:0];
            if (|prod[2*W-1:W]) exec_err = ERR_ARITH;
         end
         default: begin
            if (b_reg == '0) exec_err = ERR_ARITH;
         end
      endcase
      if (sel_bad) exec_err = ERR_SEL;
   end

   assign div_start = (state_reg == ST_EXEC) && (op_reg == OP_DIV) && (exec_err == ERR_OK);

   seq_divider #(.W(W)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .abort     (abort),
      .dividend  (a_reg),
      .divisor   (b_reg),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign lo_sel = (sel_a_reg < sel_b_reg) ? sel_a_reg : sel_b_reg;
   assign hi_sel = (sel_a_reg < sel_b_reg) ? sel_b_reg : sel_a_reg;

   // Result lands in the lower slot; everything above the upper slot slides down.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_compact
         logic [W-1:0] upper;
         if (gi < 3) begin : g_up
            assign upper = slot_reg[gi+1];
         end else begin : g_top
            assign upper = '0;
         end
         assign compact_next[gi] =
            (2'(gi) <  lo_sel)          ? slot_reg[gi] :
            (2'(gi) == lo_sel)          ? result_reg   :
            (2'(gi) <  hi_sel)          ? slot_reg[gi] :
            (3'(gi + 1) < count_reg)    ? upper        : '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         slot_reg       <= '0;
         snap_reg       <= '0;
         count_reg      <= '0;
         sel_a_reg      <= '0;
         sel_b_reg      <= '0;
         op_reg         <= OP_ADD;
         a_reg          <= '0;
         b_reg          <= '0;
         result_reg     <= '0;
         err_reg        <= ERR_OK;
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= ERR_OK;
      end else begin
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= ERR_OK;
         if (load) begin
            slot_reg  <= init_vec;
            snap_reg  <= init_vec;
            count_reg <= 3'd4;
            state_reg <= ST_READY;
         end else if (restart && state_reg != ST_IDLE) begin
            slot_reg  <= snap_reg;
            count_reg <= 3'd4;
            state_reg <= ST_READY;
         end else begin
            case (state_reg)
               ST_IDLE: state_reg <= ST_IDLE;
               ST_READY: begin
                  if (bus.req_valid && req_ready) begin
                     sel_a_reg <= bus.sel_a;
                     sel_b_reg <= bus.sel_b;
                     op_reg    <= bus.op;
                     a_reg     <= slot_reg[bus.sel_a];
                     b_reg     <= slot_reg[bus.sel_b];
                     state_reg <= ST_EXEC;
                  end
               end
               ST_EXEC: begin
                  err_reg    <= exec_err;
                  result_reg <= exec_res;
                  state_reg  <= div_start ? ST_DIV : ST_COMMIT;
               end
               ST_DIV: begin
                  if (div_done) begin
                     if (div_rem != '0) err_reg <= ERR_INEXACT;
                     else               result_reg <= div_quo;
                     state_reg <= ST_COMMIT;
                  end
               end
               ST_COMMIT: begin
                  resp_valid_reg <= 1'b1;
                  resp_err_reg   <= err_reg;
                  if (err_reg == ERR_OK) begin
                     slot_reg  <= compact_next;
                     count_reg <= count_reg - 3'd1;
                  end
                  state_reg <= ST_READY;
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_err   = resp_err_reg;

   assign num0  = slot_reg[0];
   assign num1  = slot_reg[1];
   assign num2  = slot_reg[2];
   assign num3  = slot_reg[3];
   assign count = count_reg;
   assign busy  = (state_reg == ST_EXEC) || (state_reg == ST_DIV) || (state_reg == ST_COMMIT);
   assign win   = (count_reg == 3'd1) && (slot_reg[0] == W'(TARGET));

endmodule

// File: tb/tb_move_engine.sv
// Directed-vector bench for move_engine: hand-computed slot contents, error
// codes and response latencies for each move.
module tb_move_engine;
   import move_engine_pkg::*;

   localparam int W = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         load = 1'b0;
   logic         restart = 1'b0;
   logic [W-1:0] init_num0 = '0, init_num1 = '0, init_num2 = '0, init_num3 = '0;
   logic [W-1:0] num0, num1, num2, num3;
   logic [2:0]   count;
   logic         busy, win;

   move_engine_if bus ();

   move_engine #(.W(W), .TARGET(24)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .init_num0 (init_num0),
      .init_num1 (init_num1),
      .init_num2 (init_num2),
      .init_num3 (init_num3),
      .restart   (restart),
      .bus       (bus),
      .num0      (num0),
      .num1      (num1),
      .num2      (num2),
      .num3      (num3),
      .count     (count),
      .busy      (busy),
      .win       (win)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int a, input int b, input int c, input int d);
      init_num0 = W'(a);
      init_num1 = W'(b);
      init_num2 = W'(c);
      init_num3 = W'(d);
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic chk_nums(input string tag, input int n0, input int n1, input int n2,
                           input int n3, input int c);
      check({tag, " num0"}, int'(num0), n0);
      check({tag, " num1"}, int'(num1), n1);
      check({tag, " num2"}, int'(num2), n2);
      check({tag, " num3"}, int'(num3), n3);
      check({tag, " count"}, int'(count), c);
   endtask

   // Issue one move, scramble the inputs after acceptance, and time the response.
   task automatic move(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                       input op_t o, input int exp_lat, input int exp_err);
      int lat;
      int err;
      lat = -1;
      err = -1;
      bus.sel_a     = sa;
      bus.sel_b     = sb;
      bus.op        = o;
      bus.req_valid = 1'b1;
      #1;
      check({tag, " ready"}, int'(bus.req_ready), 1);
      tick();
      bus.req_valid = 1'b0;
      bus.sel_a     = sb;
      bus.sel_b     = sa;
      bus.op        = (o == OP_ADD) ? OP_SUB : OP_ADD;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.resp_valid) begin
            lat = k;
            err = int'(bus.resp_err);
            break;
         end
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " err"}, err, exp_err);
      tick();
      check({tag, " pulse end"}, int'(bus.resp_valid), 0);
   endtask

   initial begin
      int resps;
      bus.req_valid = 1'b0;
      bus.sel_a     = 2'd0;
      bus.sel_b     = 2'd0;
      bus.op        = OP_ADD;

      repeat (3) tick();
      chk_nums("reset", 0, 0, 0, 0, 0);
      check("reset resp_valid", int'(bus.resp_valid), 0);
      check("reset resp_err", int'(bus.resp_err), 0);
      check("reset req_ready", int'(bus.req_ready), 0);
      rst_n = 1'b1;
      tick();

      // T1: 4*6
      do_load(4, 6, 1, 3);
      move("t1 mul", 2'd0, 2'd1, OP_MUL, 2, 0);
      chk_nums("t1", 24, 1, 3, 0, 3);
      check("t1 win", int'(win), 0);

      // T2: exact then inexact divide
      do_load(6, 3, 7, 2);
      move("t2 6/3", 2'd0, 2'd1, OP_DIV, 12, 0);
      chk_nums("t2a", 2, 7, 2, 0, 3);
      move("t2 7/2", 2'd1, 2'd2, OP_DIV, 12, 3);
      chk_nums("t2b", 2, 7, 2, 0, 3);

      // T3: error codes
      do_load(5, 0, 3, 9);
      move("t3 5/0", 2'd0, 2'd1, OP_DIV, 2, 2);
      move("t3 3-9", 2'd2, 2'd3, OP_SUB, 2, 2);
      chk_nums("t3a", 5, 0, 3, 9, 4);
      do_load(1000, 2, 3, 4);
      move("t3 mul ovf", 2'd0, 2'd1, OP_MUL, 2, 2);
      move("t3 sel 1,1", 2'd1, 2'd1, OP_ADD, 2, 1);
      move("t3 1000+2", 2'd0, 2'd1, OP_ADD, 2, 0);
      chk_nums("t3b", 1002, 3, 4, 0, 3);
      move("t3 sel 0,3", 2'd0, 2'd3, OP_ADD, 2, 1);
      chk_nums("t3c", 1002, 3, 4, 0, 3);

      // T4: play to a win, then ignored request
      do_load(1, 2, 3, 4);
      move("t4 1+2", 2'd0, 2'd1, OP_ADD, 2, 0);
      chk_nums("t4a", 3, 3, 4, 0, 3);
      move("t4 3+3", 2'd1, 2'd0, OP_ADD, 2, 0);
      chk_nums("t4b", 6, 4, 0, 0, 2);
      move("t4 6*4", 2'd0, 2'd1, OP_MUL, 2, 0);
      chk_nums("t4c", 24, 0, 0, 0, 1);
      check("t4 win", int'(win), 1);
      check("t4 req_ready", int'(bus.req_ready), 0);
      bus.sel_a = 2'd0;
      bus.sel_b = 2'd1;
      bus.op    = OP_ADD;
      bus.req_valid = 1'b1;
      resps = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.resp_valid) resps++;
      end
      bus.req_valid = 1'b0;
      check("t4 no resp", resps, 0);
      check("t4 count held", int'(count), 1);

      // T5: restart during divide
      do_load(8, 4, 2, 1);
      bus.sel_a = 2'd0;
      bus.sel_b = 2'd1;
      bus.op    = OP_DIV;
      bus.req_valid = 1'b1;
      #1;
      check("t5 ready", int'(bus.req_ready), 1);
      tick();
      bus.req_valid = 1'b0;
      resps = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (bus.resp_valid) resps++;
      end
      check("t5 busy in div", int'(busy), 1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      #1;
      chk_nums("t5", 8, 4, 2, 1, 4);
      check("t5 req_ready", int'(bus.req_ready), 1);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.resp_valid) resps++;
      end
      check("t5 no resp", resps, 0);

      // T6: reset mid-op, then restart in IDLE
      do_load(1, 2, 3, 4);
      bus.sel_a = 2'd0;
      bus.sel_b = 2'd1;
      bus.op    = OP_ADD;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      chk_nums("t6", 0, 0, 0, 0, 0);
      check("t6 resp_valid", int'(bus.resp_valid), 0);
      check("t6 req_ready", int'(bus.req_ready), 0);
      rst_n = 1'b1;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      resps = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.resp_valid) resps++;
      end
      chk_nums("t6 restart", 0, 0, 0, 0, 0);
      check("t6 no resp", resps, 0);
      check("t6 ready after restart", int'(bus.req_ready), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
